regbank_writeback: RTL and testbench

Write-back queue feeding the 32x64 register bank's single write port. Accepts register results from the execute/memory stages over a valid/ready handshake, buffers up to four pending writes in order, and drains one per cycle onto the bank's write port. Optionally forwards the youngest pending value for each of the bank's two read addresses so readers never see stale data while a write is queued.

---
 rtl/regbank_pkg.sv | 12 +
 rtl/regbank_writeback_if.sv | 16 +
 rtl/regbank_wb_fwd_match.sv | 24 ++
 rtl/regbank_writeback.sv | 61 ++++++
 tb/tb_regbank_writeback.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, the zero register index and the write-back entry type.
package regbank_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int WB_DEPTH = 4;
  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
  typedef struct packed {
    logic [ADDR_W-1:0] regno;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regbank_writeback_if.sv
// regbank_wb_if: producer handshake, bank write port and forwarding lookup of the write-back queue.
interface regbank_wb_if;
  import regbank_pkg::*;
  logic in_valid, in_ready, hold, regwrite, fwd_hit1, fwd_hit2;
  logic [ADDR_W-1:0] in_reg, writeregister, rd_reg1, rd_reg2;
  logic [DATA_W-1:0] in_data, datain, fwd_data1, fwd_data2;
  logic [CNT_W-1:0] count;
  modport slave (
    input in_valid, in_reg, in_data, hold, rd_reg1, rd_reg2,
    output in_ready, regwrite, writeregister, datain, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );
  modport master (
    output in_valid, in_reg, in_data, hold, rd_reg1, rd_reg2,
    input in_ready, regwrite, writeregister, datain, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/regbank_wb_fwd_match.sv
// regbank_wb_fwd_match: youngest valid entry matching one read address, walking oldest to newest.
module regbank_wb_fwd_match
  import regbank_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0]         ents,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [$clog2(DEPTH):0]        cnt,
  input  logic [ADDR_W-1:0]             rd,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);
  localparam int PW = $clog2(DEPTH);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++)
      if ((PW+1)'(k) < cnt && rd != ZERO_REG && ents[head + PW'(k)].regno == rd) begin
        hit = 1'b1;
        data = ents[head + PW'(k)].data;
      end
  end
endmodule

// File: rtl/regbank_writeback.sv
// regbank_writeback: in-order write-back queue draining one entry per cycle into the register bank.
// Forwarding of pending values is built only when REGBANK_WB_FORWARD_EN is defined.
module regbank_writeback
  import regbank_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic          clk,
  input logic          rst,
  regbank_wb_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full, pop, push;
  always_comb begin
    full = count_q == CW'(DEPTH);
    pop = count_q != '0 && !bus.hold;
    push = bus.in_valid && !full && bus.in_reg != ZERO_REG;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{regno: bus.in_reg, data: bus.in_data};
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  assign bus.in_ready = !full;
  assign bus.regwrite = pop;
  assign bus.writeregister = pop ? mem_q[rd_ptr_q].regno : '0;
  assign bus.datain = pop ? mem_q[rd_ptr_q].data : '0;
  assign bus.count = count_q;
  always_ff @(posedge clk)
    if (rst) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef REGBANK_WB_FORWARD_EN
  regbank_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .ents(mem_q), .head(rd_ptr_q), .cnt(count_q), .rd(bus.rd_reg1),
    .hit(bus.fwd_hit1), .data(bus.fwd_data1)
  );
  regbank_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .ents(mem_q), .head(rd_ptr_q), .cnt(count_q), .rd(bus.rd_reg2),
    .hit(bus.fwd_hit2), .data(bus.fwd_data2)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{bus.rd_reg1, bus.rd_reg2};
  assign bus.fwd_hit1 = 1'b0;
  assign bus.fwd_hit2 = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regbank_writeback.sv
// tb_regbank_writeback: directed vectors with hand-computed expectations for the write-back queue.
module tb_regbank_writeback;
  import regbank_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regbank_wb_if bus();
  regbank_writeback dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef REGBANK_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] r, input logic [63:0] d, input logic h);
    bus.in_valid = v;
    bus.in_reg = r;
    bus.in_data = d;
    bus.hold = h;
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bus.rd_reg1 = '0;
    bus.rd_reg2 = '0;
    drv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 0, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_regwrite", bus.regwrite, 0);
    chk("rst_wreg", bus.writeregister, 0);
    chk("rst_datain", bus.datain, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_hit1", bus.fwd_hit1, 0);
    chk("rst_fdata1", bus.fwd_data1, 0);
    chk("rst_hit2", bus.fwd_hit2, 0);
    // single write appears one cycle later, then the queue is empty again
    drv(1, 5, 64'hAA, 0);
    step();
    drv(0, 0, 0, 0);
    chk("s1_regwrite", bus.regwrite, 1);
    chk("s1_wreg", bus.writeregister, 5);
    chk("s1_datain", bus.datain, 64'hAA);
    chk("s1_count", bus.count, 1);
    step();
    chk("s1_count_after", bus.count, 0);
    chk("s1_regwrite_after", bus.regwrite, 0);
    // fill under hold, reject a fifth push, then drain in order
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), 64'h100 + 64'(i), 1);
      chk("s2_hold_nowrite", bus.regwrite, 0);
      step();
    end
    drv(1, 9, 64'h999, 1);
    chk("s2_full_count", bus.count, 4);
    chk("s2_full_ready", bus.in_ready, 0);
    step();
    drv(0, 0, 0, 0);
    chk("s2_reject_count", bus.count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("s2_drain_we", bus.regwrite, 1);
      chk("s2_drain_reg", bus.writeregister, 64'(i));
      chk("s2_drain_data", bus.datain, 64'h100 + 64'(i));
      step();
    end
    chk("s2_empty", bus.count, 0);
    chk("s2_idle_we", bus.regwrite, 0);
    // same register twice: youngest forwarded, both land in push order
    bus.rd_reg1 = 7;
    drv(1, 7, 64'h11, 1);
    chk("s3_push_not_fwd", bus.fwd_hit1, 0);
    step();
    drv(1, 7, 64'h22, 1);
    chk("s3_one_hit", bus.fwd_hit1, 64'(FWD));
    chk("s3_one_data", bus.fwd_data1, FWD ? 64'h11 : 64'h0);
    step();
    drv(0, 0, 0, 1);
    chk("s3_young_hit", bus.fwd_hit1, 64'(FWD));
    chk("s3_young_data", bus.fwd_data1, FWD ? 64'h22 : 64'h0);
    chk("s3_other_hit2", bus.fwd_hit2, 0);
    drv(0, 0, 0, 0);
    chk("s3_first_reg", bus.writeregister, 7);
    chk("s3_first_data", bus.datain, 64'h11);
    step();
    chk("s3_second_data", bus.datain, 64'h22);
    chk("s3_head_hit", bus.fwd_hit1, 64'(FWD));
    chk("s3_head_data", bus.fwd_data1, FWD ? 64'h22 : 64'h0);
    step();
    chk("s3_gone_hit", bus.fwd_hit1, 0);
    chk("s3_gone_data", bus.fwd_data1, 0);
    // XZR write completes the handshake but is dropped
    bus.rd_reg2 = 31;
    drv(1, 31, 64'hFF, 0);
    chk("s4_ready", bus.in_ready, 1);
    step();
    drv(0, 0, 0, 0);
    chk("s4_count", bus.count, 0);
    chk("s4_we", bus.regwrite, 0);
    chk("s4_hit2", bus.fwd_hit2, 0);
    // full with pop: no push this cycle, accepted next cycle
    for (int i = 10; i <= 13; i++) begin
      drv(1, 5'(i), 64'h200 + 64'(i), 1);
      step();
    end
    drv(1, 14, 64'h20E, 0);
    chk("s5_full_ready", bus.in_ready, 0);
    chk("s5_pop_reg", bus.writeregister, 10);
    step();
    drv(1, 14, 64'h20E, 1);
    chk("s5_count3", bus.count, 3);
    chk("s5_ready_again", bus.in_ready, 1);
    step();
    drv(0, 0, 0, 0);
    chk("s5_count4", bus.count, 4);
    for (int i = 11; i <= 14; i++) begin
      chk("s5_drain_reg", bus.writeregister, 64'(i));
      chk("s5_drain_data", bus.datain, 64'h200 + 64'(i));
      step();
    end
    chk("s5_empty", bus.count, 0);
    // streaming: one push per cycle never stalls
    for (int i = 0; i < 5; i++) begin
      drv(1, 5'(16 + i), 64'h300 + 64'(i), 0);
      chk("s6_stream_ready", bus.in_ready, 1);
      if (i > 0) chk("s6_stream_reg", bus.writeregister, 64'(15 + i));
      step();
    end
    drv(0, 0, 0, 0);
    chk("s6_last_reg", bus.writeregister, 20);
    step();
    // reset mid-operation discards pending entries and the concurrent push
    bus.rd_reg1 = 20;
    for (int i = 20; i <= 22; i++) begin
      drv(1, 5'(i), 64'h400 + 64'(i), 1);
      step();
    end
    drv(1, 23, 64'h417, 1);
    chk("s7_count3", bus.count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(0, 0, 0, 0);
    chk("s7_count0", bus.count, 0);
    chk("s7_we", bus.regwrite, 0);
    chk("s7_hit1", bus.fwd_hit1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("s7_never_written", bus.regwrite, 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
